// File: rtl/cellrv32_cpu_cp_fpu_f2i_issue_pkg.sv
// Shared FPU constants: fclass bit indices, fflags bit indices, rounding modes, operand classifier.
// Latency: n/a (declarations and a pure combinational helper function).
// Backpressure: n/a.
package cellrv32_cpu_cp_fpu_f2i_issue_pkg;

    // fclass one-hot bit positions (RISC-V FCLASS order)
    localparam int fp_class_neg_inf_c    = 0;
    localparam int fp_class_neg_norm_c   = 1;
    localparam int fp_class_neg_denorm_c = 2;
    localparam int fp_class_neg_zero_c   = 3;
    localparam int fp_class_pos_zero_c   = 4;
    localparam int fp_class_pos_denorm_c = 5;
    localparam int fp_class_pos_norm_c   = 6;
    localparam int fp_class_pos_inf_c    = 7;
    localparam int fp_class_snan_c       = 8;
    localparam int fp_class_qnan_c       = 9;

    // fflags bit positions
    localparam int fp_exc_nx_c = 0;
    localparam int fp_exc_uf_c = 1;
    localparam int fp_exc_of_c = 2;
    localparam int fp_exc_dz_c = 3;
    localparam int fp_exc_nv_c = 4;

    // rounding modes
    localparam logic [2:0] rm_rne_c = 3'b000;
    localparam logic [2:0] rm_rtz_c = 3'b001;
    localparam logic [2:0] rm_rdn_c = 3'b010;
    localparam logic [2:0] rm_rup_c = 3'b011;
    localparam logic [2:0] rm_rmm_c = 3'b100;
    localparam logic [2:0] rm_dyn_c = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLASSIFY,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } f2i_state_t;

    // One-hot class of an IEEE-754 single; shared with the i2f and fclass paths.
    function automatic logic [9:0] fp_classify(input logic [31:0] x);
        logic [9:0] c;
        c = '0;
        if (x[30:23] == 8'hFF) begin
            if (x[22:0] != 23'd0) begin
                if (x[22]) c[fp_class_qnan_c] = 1'b1;
                else       c[fp_class_snan_c] = 1'b1;
            end else begin
                c[x[31] ? fp_class_neg_inf_c : fp_class_pos_inf_c] = 1'b1;
            end
        end else if (x[30:23] == 8'h00) begin
            if (x[22:0] == 23'd0) c[x[31] ? fp_class_neg_zero_c   : fp_class_pos_zero_c]   = 1'b1;
            else                  c[x[31] ? fp_class_neg_denorm_c : fp_class_pos_denorm_c] = 1'b1;
        end else begin
            c[x[31] ? fp_class_neg_norm_c : fp_class_pos_norm_c] = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/cellrv32_cpu_cp_fpu_f2i_issue.sv
// Issue/retire wrapper for FCVT.W(U).S: latch+classify operand, launch converter, remap flags to fflags.
// Latency: start -> converter launch 2 cycles; converter done -> done_o 1 cycle; bad rm -> done_o 2 cycles.
// Backpressure: none; start_i is dropped while busy_o=1, flush_i aborts silently, watchdog bounds the wait.
module cellrv32_cpu_cp_fpu_f2i_issue
    import cellrv32_cpu_cp_fpu_f2i_issue_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        start_i,
    input  logic        flush_i,
    input  logic [31:0] rs1_i,
    input  logic        funct_i,
    input  logic [2:0]  instr_rm_i,
    input  logic [2:0]  csr_frm_i,
    output logic        f2i_start_o,
    output logic [2:0]  f2i_rmode_o,
    output logic        f2i_funct_o,
    output logic        f2i_sign_o,
    output logic [7:0]  f2i_exponent_o,
    output logic [22:0] f2i_mantissa_o,
    output logic [9:0]  f2i_class_o,
    input  logic [31:0] f2i_result_i,
    input  logic [4:0]  f2i_flags_i,
    input  logic        f2i_done_i,
    output logic [31:0] result_o,
    output logic [4:0]  fflags_o,
    output logic        done_o,
    output logic        illegal_o,
    output logic        busy_o
);

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    f2i_state_t       state_q, state_d;
    logic [31:0]      op_q;
    logic             funct_q;
    logic [2:0]       rm_q;
    logic [9:0]       class_q;
    logic [31:0]      res_q;
    logic [4:0]       flags_q;
    logic             illegal_q;
    logic [CNT_W-1:0] cnt_q;

    logic             rm_bad;
    logic             timeout;
    logic [4:0]       flags_remap;
    logic             unused_flags;

    // 101/110/111 are reserved once the dynamic mode has been resolved
    assign rm_bad       = rm_q[2] & (rm_q[1] | rm_q[0]);
    assign timeout      = (cnt_q == CNT_LAST);
    // divide-by-zero can never come out of a conversion
    assign unused_flags = f2i_flags_i[fp_exc_dz_c];

    // Fold converter flags into fflags: overflow becomes invalid, underflow on a nonzero input is inexact
    always_comb begin
        logic nv;
        flags_remap = '0;
        nv = f2i_flags_i[fp_exc_nv_c] | f2i_flags_i[fp_exc_of_c];
        flags_remap[fp_exc_nv_c] = nv;
        flags_remap[fp_exc_nx_c] = ~nv & (f2i_flags_i[fp_exc_nx_c] |
                                          (f2i_flags_i[fp_exc_uf_c] &
                                           ~(class_q[fp_class_neg_zero_c] | class_q[fp_class_pos_zero_c])));
    end

    // Next-state logic; flush overrides everything including a converter done in the same cycle
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:     if (start_i) state_d = S_CLASSIFY;
                S_CLASSIFY: state_d = rm_bad ? S_DONE : S_ISSUE;
                S_ISSUE:    state_d = S_WAIT;
                S_WAIT:     if (f2i_done_i || timeout) state_d = S_DONE;
                S_DONE:     state_d = S_IDLE;
                default:    state_d = S_IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Operand capture, classification, watchdog and result capture
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            op_q      <= '0;
            funct_q   <= 1'b0;
            rm_q      <= '0;
            class_q   <= '0;
            res_q     <= '0;
            flags_q   <= '0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i && !flush_i) begin
                        op_q    <= rs1_i;
                        funct_q <= funct_i;
                        rm_q    <= (instr_rm_i == rm_dyn_c) ? csr_frm_i : instr_rm_i;
                    end
                end
                S_CLASSIFY: begin
                    class_q   <= fp_classify(op_q);
                    illegal_q <= rm_bad;
                    res_q     <= '0;
                    flags_q   <= '0;
                end
                S_ISSUE: cnt_q <= '0;
                S_WAIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (f2i_done_i) begin
                        res_q   <= f2i_result_i;
                        flags_q <= flags_remap;
                    end else if (timeout) begin
                        res_q                <= '0;
                        flags_q              <= '0;
                        flags_q[fp_exc_nv_c] <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Converter operands come straight from the capture registers so they stay stable through rounding
    assign f2i_start_o    = (state_q == S_ISSUE);
    assign f2i_rmode_o    = rm_q;
    assign f2i_funct_o    = funct_q;
    assign f2i_sign_o     = op_q[31];
    assign f2i_exponent_o = op_q[30:23];
    assign f2i_mantissa_o = op_q[22:0];
    assign f2i_class_o    = class_q;

    assign done_o    = (state_q == S_DONE);
    assign result_o  = done_o ? res_q   : '0;
    assign fflags_o  = done_o ? flags_q : '0;
    assign illegal_o = done_o & illegal_q;
    assign busy_o    = (state_q != S_IDLE);

endmodule

// File: tb/tb_cellrv32_cpu_cp_fpu_f2i_issue.sv
// Bench for the f2i issue stage: behavioural converter stand-in, transaction-level model, per-cycle compare.
// Latency: n/a.
// Backpressure: n/a.
module tb_cellrv32_cpu_cp_fpu_f2i_issue;

    localparam int TIMEOUT = 64;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b1;
    logic        start_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [31:0] rs1_i = '0;
    logic        funct_i = 1'b0;
    logic [2:0]  instr_rm_i = '0;
    logic [2:0]  csr_frm_i = '0;
    logic        f2i_start_o;
    logic [2:0]  f2i_rmode_o;
    logic        f2i_funct_o;
    logic        f2i_sign_o;
    logic [7:0]  f2i_exponent_o;
    logic [22:0] f2i_mantissa_o;
    logic [9:0]  f2i_class_o;
    logic [31:0] f2i_result_i = 32'hDEADBEEF;
    logic [4:0]  f2i_flags_i = 5'h1F;
    logic        f2i_done_i = 1'b0;
    logic [31:0] result_o;
    logic [4:0]  fflags_o;
    logic        done_o;
    logic        illegal_o;
    logic        busy_o;

    cellrv32_cpu_cp_fpu_f2i_issue #(.TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .start_i(start_i), .flush_i(flush_i),
        .rs1_i(rs1_i), .funct_i(funct_i), .instr_rm_i(instr_rm_i), .csr_frm_i(csr_frm_i),
        .f2i_start_o(f2i_start_o), .f2i_rmode_o(f2i_rmode_o), .f2i_funct_o(f2i_funct_o),
        .f2i_sign_o(f2i_sign_o), .f2i_exponent_o(f2i_exponent_o), .f2i_mantissa_o(f2i_mantissa_o),
        .f2i_class_o(f2i_class_o), .f2i_result_i(f2i_result_i), .f2i_flags_i(f2i_flags_i),
        .f2i_done_i(f2i_done_i), .result_o(result_o), .fflags_o(fflags_o), .done_o(done_o),
        .illegal_o(illegal_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // ---------------- converter stand-in ----------------
    int          conv_lat   = 1;   // 0 = never answers
    int          conv_cnt   = 0;
    logic [31:0] conv_res   = '0;
    logic [4:0]  conv_flags = '0;
    logic        conv_seen  = 1'b0;

    always @(negedge clk_i) conv_seen = f2i_start_o;

    always @(posedge clk_i) begin
        #1;
        f2i_done_i   = 1'b0;
        f2i_result_i = 32'hDEADBEEF;
        f2i_flags_i  = 5'h1F;
        if (conv_seen && conv_lat > 0) conv_cnt = conv_lat;
        conv_seen = 1'b0;
        if (conv_cnt > 0) begin
            conv_cnt--;
            if (conv_cnt == 0) begin
                f2i_done_i   = 1'b1;
                f2i_result_i = conv_res;
                f2i_flags_i  = conv_flags;
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [9:0] model_class(input logic [31:0] x);
        int  idx;
        bit  neg;
        bit  all_ones;
        bit  no_exp;
        bit  frac;
        neg      = x[31];
        all_ones = (x[30:23] == 8'd255);
        no_exp   = (x[30:23] == 8'd0);
        frac     = (x[22:0] != 0);
        if (all_ones && frac)      idx = x[22] ? 9 : 8;
        else if (all_ones)         idx = neg ? 0 : 7;
        else if (no_exp && !frac)  idx = neg ? 3 : 4;
        else if (no_exp)           idx = neg ? 2 : 5;
        else                       idx = neg ? 1 : 6;
        return 10'(1) << idx;
    endfunction

    // raw converter flags {nv,dz,of,uf,nx} -> architectural fflags
    function automatic logic [4:0] model_fflags(input logic [4:0] raw, input logic [31:0] x);
        bit invalid;
        bit inexact;
        invalid = raw[4] || raw[2];
        inexact = !invalid && (raw[0] || (raw[1] && x[30:0] != 0));
        return {invalid, 3'b000, inexact};
    endfunction

    bit          m_act = 0;
    bit          m_legal;
    int          m_first, m_launch, m_done;
    logic [31:0] m_rs1, m_res;
    logic        m_funct;
    logic [2:0]  m_rm;
    logic [4:0]  m_fl;

    int          n_done = 0, n_launch = 0;
    int          last_start_cyc, last_launch_cyc, last_cdone_cyc, last_done_cyc;
    logic [31:0] last_res;
    logic [4:0]  last_fl;
    logic        last_ill;

    // Per-cycle compare against the model, then advance the model with this cycle's inputs
    always @(negedge clk_i) begin
        bit was;
        cyc++;
        if (!rstn_i) begin
            m_act = 0;
            chk("rst busy", busy_o, 0);
            chk("rst done", done_o, 0);
            chk("rst launch", f2i_start_o, 0);
            chk("rst result", result_o, 0);
            chk("rst fflags", fflags_o, 0);
            chk("rst illegal", illegal_o, 0);
            chk("rst operand", {f2i_sign_o, f2i_exponent_o, f2i_mantissa_o}, 0);
            chk("rst rm/funct/class", {f2i_rmode_o, f2i_funct_o, f2i_class_o}, 0);
        end else begin
            chk("busy", busy_o, m_act && cyc >= m_first);
            chk("launch", f2i_start_o, m_act && m_legal && cyc == m_launch);
            chk("done", done_o, m_act && cyc == m_done);
            chk("result", result_o, (m_act && cyc == m_done) ? m_res : 0);
            chk("fflags", fflags_o, (m_act && cyc == m_done) ? m_fl : 0);
            chk("illegal", illegal_o, m_act && cyc == m_done && !m_legal);
            if (m_act && cyc >= m_first) begin
                chk("operand", {f2i_sign_o, f2i_exponent_o, f2i_mantissa_o}, m_rs1);
                chk("rmode", f2i_rmode_o, m_rm);
                chk("funct", f2i_funct_o, m_funct);
            end
            if (m_act && cyc > m_first) chk("class", f2i_class_o, model_class(m_rs1));

            if (f2i_start_o) begin n_launch++; last_launch_cyc = cyc; end
            if (f2i_done_i) last_cdone_cyc = cyc;
            if (done_o) begin
                n_done++; last_done_cyc = cyc;
                last_res = result_o; last_fl = fflags_o; last_ill = illegal_o;
            end

            was = m_act;
            if (m_act && m_legal && f2i_done_i && cyc > m_launch && cyc < m_done) begin
                m_done = cyc + 1;
                m_res  = f2i_result_i;
                m_fl   = model_fflags(f2i_flags_i, m_rs1);
            end
            if (m_act && cyc == m_done) m_act = 0;
            if (flush_i) m_act = 0;
            if (!was && start_i && !flush_i) begin
                m_act    = 1;
                last_start_cyc = cyc;
                m_rs1    = rs1_i;
                m_funct  = funct_i;
                m_rm     = (instr_rm_i == 3'b111) ? csr_frm_i : instr_rm_i;
                m_legal  = (m_rm <= 3'd4);
                m_first  = cyc + 1;
                m_launch = cyc + 2;
                if (!m_legal) begin
                    m_done = cyc + 2; m_res = 0; m_fl = 0;
                end else begin
                    m_done = m_launch + TIMEOUT + 1; m_res = 0; m_fl = 5'h10;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk_i);
        #2;
    endtask

    task automatic do_op(input logic [31:0] rs1, input logic fn, input logic [2:0] irm, input logic [2:0] frm,
                         input int lat, input logic [31:0] res, input logic [4:0] fl);
        conv_lat = lat; conv_res = res; conv_flags = fl;
        rs1_i = rs1; funct_i = fn; instr_rm_i = irm; csr_frm_i = frm;
        start_i = 1'b1;
        step(1);
        start_i = 1'b0;
        rs1_i = 32'h5A5A5A5A; funct_i = ~fn; instr_rm_i = 3'b111; csr_frm_i = 3'b110;
    endtask

    task automatic wait_done(input string name, input int budget);
        int k = 0;
        while (done_o !== 1'b1 && k < budget) begin step(1); k++; end
        chk({name, " done seen"}, done_o, 1);
        step(1);
    endtask

    task automatic pin(input string name, input logic [31:0] res, input logic [4:0] fl, input logic ill);
        chk({name, " result"}, last_res, res);
        chk({name, " fflags"}, last_fl, fl);
        chk({name, " illegal"}, last_ill, ill);
    endtask

    initial begin
        int nd, nl, k;
        #500000;
        $display("FAIL global time limit: %0d checks, %0d failures", n_checks, n_fail);
        $fatal(1, "time limit");
    end

    initial begin
        int nd, nl, k;
        #1 rstn_i = 1'b0;
        step(3);
        rstn_i = 1'b1;
        step(2);

        // 3.14159 signed RNE -> 3, inexact; done one cycle after converter done
        do_op(32'h40490FDB, 1'b0, 3'b000, 3'b000, 3, 32'd3, 5'b00001);
        wait_done("pi", 20);
        pin("pi", 32'd3, 5'h01, 1'b0);
        chk("pi launch latency", last_launch_cyc - last_start_cyc, 2);
        chk("pi done latency", last_done_cyc - last_cdone_cyc, 1);
        step(4);

        // qNaN unsigned RTZ -> all ones, invalid
        do_op(32'h7FC00000, 1'b1, 3'b001, 3'b000, 2, 32'hFFFFFFFF, 5'b10000);
        wait_done("qnan", 20);
        pin("qnan", 32'hFFFFFFFF, 5'h10, 1'b0);
        step(4);

        // below -2^31: converter overflow folds into invalid
        do_op(32'hCF000001, 1'b0, 3'b001, 3'b000, 4, 32'h80000000, 5'b00100);
        wait_done("ovf", 20);
        pin("ovf", 32'h80000000, 5'h10, 1'b0);
        step(4);

        // subnormal with underflow -> inexact
        do_op(32'h00000001, 1'b0, 3'b000, 3'b000, 1, 32'd0, 5'b00010);
        wait_done("denorm", 20);
        pin("denorm", 32'd0, 5'h01, 1'b0);
        step(4);

        // -0 with underflow via dynamic rm (RDN) -> no flags
        do_op(32'h80000000, 1'b1, 3'b111, 3'b010, 2, 32'd0, 5'b00010);
        wait_done("negzero", 20);
        pin("negzero", 32'd0, 5'h00, 1'b0);
        step(4);

        // dynamic rm resolving to 101: illegal, converter never launched
        nl = n_launch;
        do_op(32'h40490FDB, 1'b0, 3'b111, 3'b101, 2, 32'd7, 5'b00001);
        wait_done("illdyn", 10);
        pin("illdyn", 32'd0, 5'h00, 1'b1);
        chk("illdyn done latency", last_done_cyc - last_start_cyc, 2);
        chk("illdyn no launch", n_launch, nl);
        step(4);

        // static rm 110 also illegal
        do_op(32'h3F800000, 1'b0, 3'b110, 3'b000, 2, 32'd1, 5'b00000);
        wait_done("ill110", 10);
        pin("ill110", 32'd0, 5'h00, 1'b1);
        chk("ill110 no launch", n_launch, nl);
        step(4);

        // converter silent: watchdog aborts with invalid
        do_op(32'h3F000000, 1'b0, 3'b011, 3'b000, 0, 32'd1, 5'b00001);
        wait_done("watchdog", 200);
        pin("watchdog", 32'd0, 5'h10, 1'b0);
        chk("watchdog span", last_done_cyc - last_launch_cyc, TIMEOUT + 1);
        step(4);

        // flush in the same cycle as converter done: no done_o, idle next cycle
        nd = n_done;
        do_op(32'h40490FDB, 1'b0, 3'b000, 3'b000, 3, 32'd3, 5'b00001);
        k = 0;
        while (f2i_done_i !== 1'b1 && k < 20) begin step(1); k++; end
        chk("flushdone converter done seen", f2i_done_i, 1);
        flush_i = 1'b1;
        step(1);
        flush_i = 1'b0;
        chk("flushdone busy after", busy_o, 0);
        step(4);
        chk("flushdone no done", n_done, nd);

        // next operation after the flush works normally
        do_op(32'hC0200000, 1'b0, 3'b001, 3'b000, 2, 32'hFFFFFFFE, 5'b00001);
        wait_done("afterflush", 20);
        pin("afterflush", 32'hFFFFFFFE, 5'h01, 1'b0);
        step(4);

        // start while busy is ignored
        nl = n_launch;
        do_op(32'h41200000, 1'b0, 3'b000, 3'b000, 5, 32'd10, 5'b00000);
        step(2);
        rs1_i = 32'h7F800000; start_i = 1'b1;
        step(1);
        start_i = 1'b0;
        wait_done("busystart", 20);
        pin("busystart", 32'd10, 5'h00, 1'b0);
        step(4);
        chk("busystart single launch", n_launch, nl + 1);

        // early flush; late converter done must be ignored
        nd = n_done;
        do_op(32'h41200000, 1'b0, 3'b000, 3'b000, 6, 32'd10, 5'b00000);
        step(3);
        flush_i = 1'b1;
        step(1);
        flush_i = 1'b0;
        step(10);
        chk("lateconv no done", n_done, nd);

        // start and flush together in idle: nothing latched
        nl = n_launch;
        rs1_i = 32'h3F800000; start_i = 1'b1; flush_i = 1'b1;
        step(1);
        start_i = 1'b0; flush_i = 1'b0;
        chk("startflush busy", busy_o, 0);
        step(4);
        chk("startflush no launch", n_launch, nl);

        // reset mid-operation, then recover
        nd = n_done;
        do_op(32'h40490FDB, 1'b0, 3'b000, 3'b000, 5, 32'd3, 5'b00001);
        step(3);
        rstn_i = 1'b0;
        step(2);
        rstn_i = 1'b1;
        step(8);
        chk("midreset no done", n_done, nd);
        do_op(32'hBF800000, 1'b0, 3'b100, 3'b000, 2, 32'hFFFFFFFF, 5'b00000);
        wait_done("afterreset", 20);
        pin("afterreset", 32'hFFFFFFFF, 5'h00, 1'b0);
        step(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
